demo_serial_tx: RTL

Asynchronous serial (UART-style) transmitter for the demo standard-cell flow. It accepts a parallel word through a valid/ready handshake and shifts it out LSB-first on a single line as start bit, data bits, optional parity and stop bit(s). It is the transmit end of the demo serial link. It is built so that synthesis maps it onto the demo cell set (BUF/NOT/NAND/NOR/DFF) with no asynchronous set/reset.

---
 rtl/demo_serial_pkg.sv | 16 +
 rtl/demo_bit_timer.sv | 22 ++
 rtl/demo_serial_tx.sv | 109 ++++++++++
 3 files changed

// File: rtl/demo_serial_pkg.sv
// Shared definitions for the demo serial link (transmitter and receiver).
package demo_serial_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/demo_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module demo_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic C,
  input  logic CLR,
  output logic TICK
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge C) begin
    if (CLR || cnt == LAST) cnt <= '0;
    else                    cnt <= cnt + 1'b1;
  end

  assign TICK = (cnt == LAST);

endmodule

// File: rtl/demo_serial_tx.sv
// UART-style transmitter: start bit, LSB-first data, optional parity, stop bit(s).
module demo_serial_tx
  import demo_serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              C,
  input  logic              R,
  input  logic [DATA_W-1:0] D,
  input  logic              VALID,
  output logic              READY,
  output logic              Y,
  output logic              BUSY
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  state_t            state, state_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [BW-1:0]     bit_cnt, bit_cnt_n;
  logic              par_bit, par_bit_n;
  logic              y_n, ready_n;
  logic              tick;

  // Timer is held cleared while idle so START always gets a full bit period.
  demo_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .C    (C),
    .CLR  (R || state == IDLE),
    .TICK (tick)
  );

  always_ff @(posedge C) begin
    if (R) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      par_bit <= 1'b0;
      Y       <= 1'b1;
      READY   <= 1'b1;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bit_cnt <= bit_cnt_n;
      par_bit <= par_bit_n;
      Y       <= y_n;
      READY   <= ready_n;
    end
  end

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    par_bit_n = par_bit;
    unique case (state)
      IDLE: if (VALID) begin
        state_n   = START;
        shreg_n   = D;
        par_bit_n = (PARITY == PAR_ODD) ? ~(^D) : ^D;
      end
      START: if (tick) begin
        state_n   = DATA;
        bit_cnt_n = '0;
      end
      DATA: if (tick) begin
        shreg_n = shreg >> 1;
        if (bit_cnt == LAST_BIT) begin
          bit_cnt_n = '0;
          state_n   = (PARITY != PAR_NONE) ? PAR : STOP;
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      PAR: if (tick) begin
        state_n   = STOP;
        bit_cnt_n = '0;
      end
      STOP: if (tick) begin
        if (bit_cnt == LAST_STOP) begin
          state_n   = IDLE;
          bit_cnt_n = '0;
        end else begin
          bit_cnt_n = bit_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Line level is derived from the next state so Y can be a plain register.
  always_comb begin
    y_n = 1'b1;
    unique case (state_n)
      START:   y_n = 1'b0;
      DATA:    y_n = shreg_n[0];
      PAR:     y_n = par_bit_n;
      default: y_n = 1'b1;
    endcase
    ready_n = (state_n == IDLE);
  end

  assign BUSY = ~READY;

endmodule
